fc_argmax_classifier: RTL

//  Consumer end of the fully_connected output interface. Captures one parallel

---
 rtl/fc_argmax_classifier.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fc_argmax_classifier.sv
// Argmax over one captured FC score vector, scanned one class per clock.
// Optional FC_ARGMAX_THRESH_EN adds a threshold input and class_detected output.
module fc_argmax_classifier #(
    parameter int NUM_CLASSES = 4,
    parameter int DATA_BITS   = 8,
    parameter int IDX_BITS    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLASSES*DATA_BITS-1:0] in_data,
    input  logic                             in_valid,
`ifdef FC_ARGMAX_THRESH_EN
    input  logic [DATA_BITS-1:0]             threshold,
    output logic                             class_detected,
`endif
    output logic                             in_ready,
    output logic [IDX_BITS-1:0]              class_idx,
    output logic [DATA_BITS-1:0]             class_score,
    output logic                             class_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

    state_t state;
    state_t state_nxt;

    logic signed [DATA_BITS-1:0] lanes [NUM_CLASSES];
    logic signed [DATA_BITS-1:0] best_score;
    logic signed [DATA_BITS-1:0] cur_score;
    logic signed [DATA_BITS-1:0] win_score;
    logic [IDX_BITS-1:0]         best_idx;
    logic [IDX_BITS-1:0]         win_idx;
    logic [IDX_BITS-1:0]         cnt;
    logic                        capture;
    logic                        last;

`ifdef FC_ARGMAX_THRESH_EN
    logic signed [DATA_BITS-1:0] thresh_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        capture   = 1'b0;
        last      = (cnt == LAST_IDX);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict '>' keeps the lowest index among equal maxima.
    always_comb begin
        cur_score = lanes[cnt];
        win_score = best_score;
        win_idx   = best_idx;
        if (cur_score > best_score) begin
            win_score = cur_score;
            win_idx   = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                lanes[i] <= '0;
            end
            best_score  <= '0;
            best_idx    <= '0;
            cnt         <= '0;
            class_idx   <= '0;
            class_score <= '0;
            class_valid <= 1'b0;
`ifdef FC_ARGMAX_THRESH_EN
            thresh_q       <= '0;
            class_detected <= 1'b0;
`endif
        end else begin
            class_valid <= 1'b0;
            if (capture) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    lanes[i] <= in_data[i*DATA_BITS +: DATA_BITS];
                end
                best_score <= in_data[DATA_BITS-1:0];
                best_idx   <= '0;
                cnt        <= IDX_BITS'(1);
`ifdef FC_ARGMAX_THRESH_EN
                thresh_q   <= threshold;
`endif
            end else if (state == SCAN) begin
                best_score <= win_score;
                best_idx   <= win_idx;
                if (last) begin
                    class_idx   <= win_idx;
                    class_score <= win_score;
                    class_valid <= 1'b1;
                    cnt         <= '0;
`ifdef FC_ARGMAX_THRESH_EN
                    class_detected <= (win_score >= thresh_q);
`endif
                end else begin
                    cnt <= cnt + IDX_BITS'(1);
                end
            end
        end
    end

endmodule
